mem_access_unit: RTL and testbench

Sequential load/store controller between the MEM pipeline stage and the data-memory bus. It checks alignment, drives a req/ack bus transaction with byte-lane enables, and holds the stage stalled until the transaction ends. For loads, it registers the returned word together with offset, size and extension controls. These registered outputs feed the read-data decoder stage directly.

---
 rtl/mem_access_pkg.sv | 27 ++
 rtl/store_lane_encoder.sv | 41 ++++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store controller: access sizes,
// controller states and the alignment rule.
package mem_access_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } accState_e;

  // True when the size code is legal and the byte offset suits it.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      SIZE_WORD: ok = (offset == 2'd0);
      SIZE_HALF: ok = (offset[0] == 1'b0);
      SIZE_BYTE: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_lane_encoder.sv
// Big-endian store lane steering: replicates store data across the bus lanes
// and selects the byte enables for the addressed bytes.
module store_lane_encoder
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] laneData
);

  // Lane enables and replicated data per access size.
  always_comb begin
    be       = 4'b0000;
    laneData = 32'h0000_0000;
    case (size)
      SIZE_WORD: begin
        be       = 4'b1111;
        laneData = wdata;
      end
      SIZE_HALF: begin
        laneData = {wdata[15:0], wdata[15:0]};
        if (offset[1] == 1'b0) begin
          be = 4'b1100;
        end else begin
          be = 4'b0011;
        end
      end
      SIZE_BYTE: begin
        laneData = {4{wdata[7:0]}};
        be       = 4'b1000 >> offset;
      end
      default: begin
        be       = 4'b0000;
        laneData = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller between the MEM stage and the data-memory bus:
// alignment check, req/ack handshake with timeout, and load-result capture.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  dataSize,
  input  logic        bitExt,
  output logic        stall,
  output logic        loadValid,
  output logic        accessErr,
  output logic        busErr,
  output logic [31:0] dec_data,
  output logic [1:0]  dec_offset,
  output logic [1:0]  dec_size,
  output logic        dec_bitExt,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  accState_e   state_r, nextState_s;
  logic [CW-1:0] timeoutCnt_r;
  logic        reqPresent_s, reqLegal_s;
  logic        latch_s, illegal_s, ackHit_s, timeout_s;
  logic [3:0]  encBe_s;
  logic [31:0] encData_s;
  logic        busReq_r, busWe_r;
  logic [31:0] busAddr_r, busWdata_r;
  logic [3:0]  busBe_r;
  logic [1:0]  latchSize_r, latchOff_r;
  logic        latchExt_r;
  logic        loadValid_r, accessErr_r, busErr_r;
  logic [31:0] decData_r;
  logic [1:0]  decOffset_r, decSize_r;
  logic        decExt_r;

  store_lane_encoder uEnc (
    .size     (dataSize),
    .offset   (addr[1:0]),
    .wdata    (wdata),
    .be       (encBe_s),
    .laneData (encData_s)
  );

  assign reqPresent_s = memRead | memWrite;
  assign reqLegal_s   = (memRead ^ memWrite) & isAligned(dataSize, addr[1:0]);
  // Stall must be visible in the sampling cycle, so it is decoded from inputs.
  assign stall = ((state_r == IDLE) & reqPresent_s & reqLegal_s) | (state_r == REQ);

  // Next-state decode and transaction events.
  always_comb begin
    nextState_s = state_r;
    latch_s     = 1'b0;
    illegal_s   = 1'b0;
    ackHit_s    = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (reqPresent_s) begin
          if (reqLegal_s) begin
            latch_s     = 1'b1;
            nextState_s = REQ;
          end else begin
            illegal_s   = 1'b1;
            nextState_s = IDLE;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      REQ: begin
        if (bus_ack) begin
          ackHit_s    = 1'b1;
          nextState_s = DONE;
        end else if (timeoutCnt_r == LAST_CNT) begin
          timeout_s   = 1'b1;
          nextState_s = DONE;
        end else begin
          nextState_s = REQ;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register and REQ-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      timeoutCnt_r <= '0;
    end else begin
      state_r <= nextState_s;
      if ((state_r == REQ) && (nextState_s == REQ)) begin
        timeoutCnt_r <= timeoutCnt_r + CW'(1);
      end else begin
        timeoutCnt_r <= '0;
      end
    end
  end

  // Bus outputs, status pulses and decoder capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busReq_r    <= 1'b0;
      busWe_r     <= 1'b0;
      busAddr_r   <= 32'h0000_0000;
      busWdata_r  <= 32'h0000_0000;
      busBe_r     <= 4'b0000;
      latchSize_r <= 2'b00;
      latchOff_r  <= 2'b00;
      latchExt_r  <= 1'b0;
      loadValid_r <= 1'b0;
      accessErr_r <= 1'b0;
      busErr_r    <= 1'b0;
      decData_r   <= 32'h0000_0000;
      decOffset_r <= 2'b00;
      decSize_r   <= 2'b00;
      decExt_r    <= 1'b0;
    end else begin
      accessErr_r <= illegal_s;
      busErr_r    <= timeout_s;
      loadValid_r <= ackHit_s & ~busWe_r;
      if (latch_s) begin
        busReq_r    <= 1'b1;
        busWe_r     <= memWrite;
        busAddr_r   <= {addr[31:2], 2'b00};
        busWdata_r  <= encData_s;
        busBe_r     <= memWrite ? encBe_s : 4'b1111;
        latchSize_r <= dataSize;
        latchOff_r  <= addr[1:0];
        latchExt_r  <= bitExt;
      end else if (ackHit_s | timeout_s) begin
        busReq_r <= 1'b0;
      end else begin
        busReq_r <= busReq_r;
      end
      // Stores leave the decoder registers untouched; a timeout clears the data word.
      if (ackHit_s & ~busWe_r) begin
        decData_r   <= bus_rdata;
        decOffset_r <= latchOff_r;
        decSize_r   <= latchSize_r;
        decExt_r    <= latchExt_r;
      end else if (timeout_s) begin
        decData_r <= 32'h0000_0000;
      end else begin
        decData_r <= decData_r;
      end
    end
  end

  assign bus_req    = busReq_r;
  assign bus_we     = busWe_r;
  assign bus_addr   = busAddr_r;
  assign bus_wdata  = busWdata_r;
  assign bus_be     = busBe_r;
  assign loadValid  = loadValid_r;
  assign accessErr  = accessErr_r;
  assign busErr     = busErr_r;
  assign dec_data   = decData_r;
  assign dec_offset = decOffset_r;
  assign dec_size   = decSize_r;
  assign dec_bitExt = decExt_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRead, memWrite, bitExt;
  logic [31:0] addr, wdata;
  logic [1:0]  dataSize;
  logic        stall, loadValid, accessErr, busErr;
  logic [31:0] dec_data;
  logic [1:0]  dec_offset, dec_size;
  logic        dec_bitExt;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wdata(wdata), .dataSize(dataSize), .bitExt(bitExt),
    .stall(stall), .loadValid(loadValid), .accessErr(accessErr), .busErr(busErr),
    .dec_data(dec_data), .dec_offset(dec_offset), .dec_size(dec_size),
    .dec_bitExt(dec_bitExt), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dropReq();
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] shifted;
    logic [31:0] decoded;
    int          reqCycles;
    int          stallCycles;
    logic        errSeen;

    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    dataSize = 2'd0; bitExt = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    checkEq("rst_stall", {31'd0, stall}, 32'd0);
    checkEq("rst_bus_req", {31'd0, bus_req}, 32'd0);
    checkEq("rst_bus_addr", bus_addr, 32'h0);
    checkEq("rst_bus_be", {28'd0, bus_be}, 32'h0);
    checkEq("rst_pulses", {29'd0, loadValid, accessErr, busErr}, 32'h0);
    checkEq("rst_dec_data", dec_data, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Load byte at 0x103, one-cycle ack
    memRead = 1'b1; addr = 32'h0000_0103; dataSize = 2'd2; bitExt = 1'b0;
    #1;
    checkEq("lb_stall_c0", {31'd0, stall}, 32'd1);
    checkEq("lb_req_c0", {31'd0, bus_req}, 32'd0);
    step();
    checkEq("lb_req_c1", {31'd0, bus_req}, 32'd1);
    checkEq("lb_bus_addr", bus_addr, 32'h0000_0100);
    checkEq("lb_bus_be", {28'd0, bus_be}, 32'hF);
    checkEq("lb_bus_we", {31'd0, bus_we}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    step();
    bus_ack = 1'b0;
    checkEq("lb_loadValid", {31'd0, loadValid}, 32'd1);
    checkEq("lb_stall_done", {31'd0, stall}, 32'd0);
    checkEq("lb_req_done", {31'd0, bus_req}, 32'd0);
    checkEq("lb_dec_data", dec_data, 32'h1122_3344);
    checkEq("lb_dec_offset", {30'd0, dec_offset}, 32'd3);
    checkEq("lb_dec_size", {30'd0, dec_size}, 32'd2);
    shifted = dec_data >> (5'd24 - {dec_offset, 3'b000});
    decoded = dec_bitExt ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    checkEq("lb_decoded", decoded, 32'h0000_0044);
    dropReq();
    step();
    checkEq("lb_pulse_end", {31'd0, loadValid}, 32'd0);

    // Store half at 0x202
    memWrite = 1'b1; addr = 32'h0000_0202; wdata = 32'h0000_ABCD; dataSize = 2'd1;
    step();
    checkEq("sh_bus_be", {28'd0, bus_be}, 32'h3);
    checkEq("sh_bus_wdata", bus_wdata, 32'hABCD_ABCD);
    checkEq("sh_bus_we", {31'd0, bus_we}, 32'd1);
    checkEq("sh_bus_addr", bus_addr, 32'h0000_0200);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    checkEq("sh_loadValid", {31'd0, loadValid}, 32'd0);
    checkEq("sh_dec_hold", dec_data, 32'h1122_3344);
    dropReq();
    step();

    // Misaligned word load
    memRead = 1'b1; addr = 32'h0000_0101; dataSize = 2'd0;
    #1;
    checkEq("mis_stall", {31'd0, stall}, 32'd0);
    step();
    checkEq("mis_accessErr", {31'd0, accessErr}, 32'd1);
    checkEq("mis_bus_req", {31'd0, bus_req}, 32'd0);
    dropReq();
    step();
    checkEq("mis_pulse_end", {31'd0, accessErr}, 32'd0);

    // Read and write both requested
    memRead = 1'b1; memWrite = 1'b1; addr = 32'h0000_0600; dataSize = 2'd0;
    #1;
    checkEq("both_stall", {31'd0, stall}, 32'd0);
    step();
    checkEq("both_accessErr", {31'd0, accessErr}, 32'd1);
    checkEq("both_bus_req", {31'd0, bus_req}, 32'd0);
    dropReq();
    step();

    // Load with no ack: timeout after 4 REQ cycles
    memRead = 1'b1; addr = 32'h0000_0300; dataSize = 2'd0;
    reqCycles = 0; errSeen = 1'b0;
    for (int i = 0; i < 12 && !errSeen; i++) begin
      step();
      if (bus_req) reqCycles++;
      if (busErr) errSeen = 1'b1;
    end
    checkEq("to_busErr_seen", {31'd0, errSeen}, 32'd1);
    checkEq("to_req_cycles", reqCycles, 32'd4);
    checkEq("to_dec_data", dec_data, 32'h0);
    checkEq("to_loadValid", {31'd0, loadValid}, 32'd0);
    checkEq("to_stall", {31'd0, stall}, 32'd0);
    dropReq();
    step();
    checkEq("to_pulse_end", {31'd0, busErr}, 32'd0);

    // Half load at 0x402, ack in the third REQ cycle
    memRead = 1'b1; addr = 32'h0000_0402; dataSize = 2'd1; bitExt = 1'b1;
    bus_rdata = 32'h8899_AABB;
    #1;
    stallCycles = stall ? 1 : 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (stall) stallCycles++;
      checkEq($sformatf("dly_addr_%0d", k), bus_addr, 32'h0000_0400);
      checkEq($sformatf("dly_be_%0d", k), {28'd0, bus_be}, 32'hF);
      checkEq($sformatf("dly_req_%0d", k), {31'd0, bus_req}, 32'd1);
      if (k == 3) bus_ack = 1'b1;
    end
    step();
    bus_ack = 1'b0;
    checkEq("dly_stall_cycles", stallCycles, 32'd4);
    checkEq("dly_stall_done", {31'd0, stall}, 32'd0);
    checkEq("dly_loadValid", {31'd0, loadValid}, 32'd1);
    checkEq("dly_dec_data", dec_data, 32'h8899_AABB);
    checkEq("dly_dec_offset", {30'd0, dec_offset}, 32'd2);
    checkEq("dly_dec_size", {30'd0, dec_size}, 32'd1);
    checkEq("dly_dec_bitExt", {31'd0, dec_bitExt}, 32'd1);
    dropReq();
    step();

    // Store byte at offset 1
    memWrite = 1'b1; addr = 32'h0000_0501; wdata = 32'h1234_56EF; dataSize = 2'd2;
    step();
    checkEq("sb_bus_be", {28'd0, bus_be}, 32'h4);
    checkEq("sb_bus_wdata", bus_wdata, 32'hEFEF_EFEF);
    checkEq("sb_bus_addr", bus_addr, 32'h0000_0500);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    checkEq("sb_loadValid", {31'd0, loadValid}, 32'd0);
    checkEq("sb_dec_hold", dec_data, 32'h8899_AABB);
    dropReq();
    step();

    // Stray ack while idle
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_ack = 1'b0;
    checkEq("idle_ack_req", {31'd0, bus_req}, 32'd0);
    checkEq("idle_ack_loadValid", {31'd0, loadValid}, 32'd0);
    checkEq("idle_ack_dec", dec_data, 32'h8899_AABB);

    // Reset asserted during REQ
    memWrite = 1'b1; addr = 32'h0000_0700; wdata = 32'hCAFE_F00D; dataSize = 2'd0;
    step();
    checkEq("rr_req_before", {31'd0, bus_req}, 32'd1);
    checkEq("rr_wdata", bus_wdata, 32'hCAFE_F00D);
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("rr_req_async", {31'd0, bus_req}, 32'd0);
    dropReq();
    step();
    rst_n = 1'b1;
    step();
    checkEq("rr_stall", {31'd0, stall}, 32'd0);
    checkEq("rr_pulses", {29'd0, loadValid, accessErr, busErr}, 32'h0);
    checkEq("rr_bus_req", {31'd0, bus_req}, 32'd0);
    checkEq("rr_dec_data", dec_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
